life_gen_engine: RTL and testbench

- Consumer end of the grid address walk. It drives `walk_en` and takes the row/col address the walker presents.
- For each cell it fetches the 3x3 toroidal neighbourhood from a ping-pong cell memory and applies rule B3/S23. It writes the next state into the opposite page.
- Sits between the address walker, the cell RAM (2 pages of 2^K x 2^K bits) and the top-level generation/step control.

---
 rtl/life_gen_engine_pkg.sv | 19 +
 rtl/life_rule.sv | 12 +
 rtl/life_gen_engine.sv | 138 +++++++++++++
 tb/tb_life_gen_engine.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/life_gen_engine_pkg.sv
// Shared state encoding and rule constants for the Game-of-Life generation engine.
package life_gen_engine_pkg;

    localparam int K_DEFAULT = 7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LAST  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] FETCH_LAST = 4'd8;
    localparam logic [3:0] CENTRE_IDX = 4'd4;
    localparam logic [3:0] BIRTH_N    = 4'd3;
    localparam logic [3:0] SURVIVE_N  = 4'd2;

endpackage

// File: rtl/life_rule.sv
// Cellular-automaton next-state rule (B3/S23); isolated so other rules can be dropped in.
module life_rule
    import life_gen_engine_pkg::*;
(
    input  logic       self,
    input  logic [3:0] ncount,
    output logic       next
);

    assign next = (ncount == BIRTH_N) | (self & (ncount == SURVIVE_N));

endmodule

// File: rtl/life_gen_engine.sv
// Walks every cell of a toroidal grid, reads its 3x3 neighbourhood from the source page
// and writes the B3/S23 next state into the opposite page of a ping-pong cell RAM.
module life_gen_engine
    import life_gen_engine_pkg::*;
#(
    parameter int K  = K_DEFAULT,
    parameter int AW = 2*K+1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          walk_en,
    input  logic [K-1:0]  cell_r,
    input  logic [K-1:0]  cell_c,
    input  logic          walk_done,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    input  logic          mem_rd_data,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_wr_addr,
    output logic          mem_wr_data,
    output logic          page,
    output logic          busy,
    output logic          gen_done
);

    state_t      state, state_nx;
    logic [3:0]  idx;
    logic [3:0]  ncount;
    logic        cell_self;
    logic        next_bit;
    logic [1:0]  row_sel, col_sel;
    logic [K-1:0] rd_row, rd_col;

    // sel 0/1/2 means offset -1/0/+1, modulo 2^K so the grid wraps as a torus
    function automatic logic [K-1:0] step(input logic [1:0] sel);
        case (sel)
            2'd0:    return '1;
            2'd1:    return '0;
            default: return K'(1);
        endcase
    endfunction

    always_comb begin
        row_sel = 2'd0;
        col_sel = 2'd0;
        case (idx)
            4'd0: begin row_sel = 2'd0; col_sel = 2'd0; end
            4'd1: begin row_sel = 2'd0; col_sel = 2'd1; end
            4'd2: begin row_sel = 2'd0; col_sel = 2'd2; end
            4'd3: begin row_sel = 2'd1; col_sel = 2'd0; end
            4'd4: begin row_sel = 2'd1; col_sel = 2'd1; end
            4'd5: begin row_sel = 2'd1; col_sel = 2'd2; end
            4'd6: begin row_sel = 2'd2; col_sel = 2'd0; end
            4'd7: begin row_sel = 2'd2; col_sel = 2'd1; end
            4'd8: begin row_sel = 2'd2; col_sel = 2'd2; end
            default: begin row_sel = 2'd0; col_sel = 2'd0; end
        endcase
    end

    assign rd_row = cell_r + step(row_sel);
    assign rd_col = cell_c + step(col_sel);

    life_rule u_rule (
        .self   (cell_self),
        .ncount (ncount),
        .next   (next_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= 4'd0;
            ncount    <= 4'd0;
            cell_self <= 1'b0;
            page      <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx    <= 4'd0;
                        ncount <= 4'd0;
                    end
                end
                S_FETCH: begin
                    idx <= idx + 4'd1;
                    // read data lags the address by one cycle, so it belongs to idx-1
                    if (idx != 4'd0) begin
                        if (idx == CENTRE_IDX + 4'd1) cell_self <= mem_rd_data;
                        else                          ncount    <= ncount + {3'b000, mem_rd_data};
                    end
                end
                S_LAST:  ncount <= ncount + {3'b000, mem_rd_data};
                S_WRITE: begin
                    idx    <= 4'd0;
                    ncount <= 4'd0;
                end
                S_DONE:  page <= ~page;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx    = state;
        walk_en     = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = 1'b0;
        gen_done    = 1'b0;
        busy        = (state != S_IDLE);
        case (state)
            S_IDLE:  if (start) state_nx = S_FETCH;
            S_FETCH: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = {page, rd_row, rd_col};
                if (idx == FETCH_LAST) state_nx = S_LAST;
            end
            S_LAST:  state_nx = S_WRITE;
            S_WRITE: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = {~page, cell_r, cell_c};
                mem_wr_data = next_bit;
                walk_en     = 1'b1;
                state_nx    = walk_done ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                gen_done = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_life_gen_engine.sv
// Directed bench: a K=2 and a K=3 engine, each with a walker and a ping-pong cell RAM model.
module tb_life_gen_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // K=2 instance
    logic       a_start = 1'b0, a_walk_en, a_walk_done, a_rd_en, a_rd_data, a_wr_en, a_wr_data;
    logic       a_page, a_busy, a_gen_done;
    logic [1:0] a_r, a_c;
    logic [4:0] a_rd_addr, a_wr_addr;
    logic [3:0] a_widx;
    logic       a_mem [0:31];

    // K=3 instance
    logic       b_start = 1'b0, b_walk_en, b_walk_done, b_rd_en, b_rd_data, b_wr_en, b_wr_data;
    logic       b_page, b_busy, b_gen_done;
    logic [2:0] b_r, b_c;
    logic [6:0] b_rd_addr, b_wr_addr;
    logic [5:0] b_widx;
    logic       b_mem [0:127];

    life_gen_engine #(.K(2)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .walk_en(a_walk_en),
        .cell_r(a_r), .cell_c(a_c), .walk_done(a_walk_done),
        .mem_rd_en(a_rd_en), .mem_rd_addr(a_rd_addr), .mem_rd_data(a_rd_data),
        .mem_wr_en(a_wr_en), .mem_wr_addr(a_wr_addr), .mem_wr_data(a_wr_data),
        .page(a_page), .busy(a_busy), .gen_done(a_gen_done)
    );

    life_gen_engine #(.K(3)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .walk_en(b_walk_en),
        .cell_r(b_r), .cell_c(b_c), .walk_done(b_walk_done),
        .mem_rd_en(b_rd_en), .mem_rd_addr(b_rd_addr), .mem_rd_data(b_rd_data),
        .mem_wr_en(b_wr_en), .mem_wr_addr(b_wr_addr), .mem_wr_data(b_wr_data),
        .page(b_page), .busy(b_busy), .gen_done(b_gen_done)
    );

    // walkers: row-major counters that wrap after the last cell
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a_widx <= '0;
            b_widx <= '0;
        end else begin
            if (a_walk_en) a_widx <= a_widx + 4'd1;
            if (b_walk_en) b_widx <= b_widx + 6'd1;
        end
    end
    assign a_r = a_widx[3:2];
    assign a_c = a_widx[1:0];
    assign a_walk_done = &a_widx;
    assign b_r = b_widx[5:3];
    assign b_c = b_widx[2:0];
    assign b_walk_done = &b_widx;

    // cell RAMs with one-cycle read latency
    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
        if (a_wr_en) a_mem[a_wr_addr] = a_wr_data;
        if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
        if (b_wr_en) b_mem[b_wr_addr] = b_wr_data;
    end

    // monitors
    int a_walk_cnt, a_last_walk, a_first_walk, a_gap_bad, a_wr_cnt, a_wr_ones, a_gen_cnt, a_gd_cyc;
    int b_gen_cnt, b_max;
    int a_log_n = 9;
    logic [4:0] a_rd_log [0:8];
    int start_cyc;

    always @(negedge clk) begin
        if (a_walk_en) begin
            if (a_walk_cnt > 0 && (cyc - a_last_walk) != 11) a_gap_bad++;
            if (a_walk_cnt == 0) a_first_walk = cyc;
            a_last_walk = cyc;
            a_walk_cnt++;
        end
        if (a_wr_en) begin
            a_wr_cnt++;
            if (a_wr_data) a_wr_ones++;
        end
        if (a_rd_en && a_log_n < 9) begin
            a_rd_log[a_log_n] = a_rd_addr;
            a_log_n++;
        end
        if (a_gen_done) begin
            a_gen_cnt++;
            a_gd_cyc = cyc;
        end
        if (b_gen_done) b_gen_cnt++;
        if (int'(u_b.ncount) > b_max) b_max = int'(u_b.ncount);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mems();
        for (int i = 0; i < 32; i++) a_mem[i] = 1'b0;
        for (int i = 0; i < 128; i++) b_mem[i] = 1'b0;
    endtask

    function automatic logic [15:0] a_page_vec(input int p);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = a_mem[p*16 + i];
        return v;
    endfunction

    function automatic logic [63:0] b_page_vec(input int p);
        logic [63:0] v;
        for (int i = 0; i < 64; i++) v[i] = b_mem[p*64 + i];
        return v;
    endfunction

    task automatic reset_mon();
        a_walk_cnt = 0; a_gap_bad = 0; a_wr_cnt = 0; a_wr_ones = 0;
    endtask

    task automatic run_gen(input bit on_b, input bit stray, input int budget);
        int  g0;
        bit  seen;
        g0 = on_b ? b_gen_cnt : a_gen_cnt;
        @(negedge clk);
        if (on_b) b_start = 1'b1; else a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0; b_start = 1'b0;
        start_cyc = cyc;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(posedge clk); #1;
            a_start = 1'b0; b_start = 1'b0;
            if (stray && (n == 20 || n == 77 || n == 150)) begin
                if (on_b) b_start = 1'b1; else a_start = 1'b1;
            end
            #1;
            seen = ((on_b ? b_gen_cnt : a_gen_cnt) != g0);
        end
        a_start = 1'b0; b_start = 1'b0;
        if (!seen) check_eq("gen_timeout", 64'd0, 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [4:0] exp_rd [0:8];
    int g_before;

    initial begin
        clear_mems();
        reset_mon();
        a_gen_cnt = 0; b_gen_cnt = 0; b_max = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outs_a", {a_walk_en, a_rd_en, a_rd_addr, a_wr_en, a_wr_addr, a_wr_data,
                                  a_page, a_busy, a_gen_done}, 64'd0);
        check_eq("reset_outs_b", {b_walk_en, b_rd_en, b_rd_addr, b_wr_en, b_wr_addr, b_wr_data,
                                  b_page, b_busy, b_gen_done}, 64'd0);
        @(negedge clk) rst = 1'b0;

        // asynchronous reset in the middle of the neighbourhood fetch
        @(negedge clk) a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("busy_before_rst", {a_busy, a_rd_en}, 64'd3);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_outs", {a_walk_en, a_rd_en, a_rd_addr, a_wr_en, a_wr_addr, a_wr_data,
                                    a_page, a_busy, a_gen_done}, 64'd0);
        @(negedge clk) rst = 1'b0;
        reset_mon();
        repeat (30) @(posedge clk);
        #1;
        check_eq("no_walk_after_rst", a_walk_cnt, 0);
        check_eq("idle_after_rst", {a_busy, a_page}, 64'd0);

        // empty 4x4 grid, with stray start pulses while busy
        reset_mon();
        g_before = a_gen_cnt;
        run_gen(1'b0, 1'b1, 400);
        check_eq("empty_walks", a_walk_cnt, 16);
        check_eq("empty_walk_gap", a_gap_bad, 0);
        check_eq("empty_first_walk", a_first_walk - start_cyc, 10);
        check_eq("empty_gen_done_cyc", a_gd_cyc - start_cyc, 176);
        check_eq("empty_page", a_page, 1);
        check_eq("empty_writes", a_wr_cnt, 16);
        check_eq("empty_write_ones", a_wr_ones, 0);
        repeat (30) @(posedge clk);
        #1;
        check_eq("stray_start_gens", a_gen_cnt - g_before, 1);
        check_eq("stray_start_idle", a_busy, 0);

        // 2x2 block straddling the wrap corner, source page 1
        for (int i = 0; i < 32; i++) a_mem[i] = 1'b0;
        a_mem[16 + 0] = 1'b1; a_mem[16 + 3] = 1'b1;
        a_mem[16 + 12] = 1'b1; a_mem[16 + 15] = 1'b1;
        run_gen(1'b0, 1'b0, 400);
        check_eq("corner_block", a_page_vec(0), 16'h9009);
        check_eq("corner_page", a_page, 0);

        // lone cell at (1,1) dies; check neighbourhood read order of cell (0,0)
        for (int i = 0; i < 32; i++) a_mem[i] = 1'b0;
        a_mem[5] = 1'b1;
        exp_rd[0] = 5'd15; exp_rd[1] = 5'd12; exp_rd[2] = 5'd13;
        exp_rd[3] = 5'd3;  exp_rd[4] = 5'd0;  exp_rd[5] = 5'd1;
        exp_rd[6] = 5'd7;  exp_rd[7] = 5'd4;  exp_rd[8] = 5'd5;
        a_log_n = 0;
        run_gen(1'b0, 1'b0, 400);
        for (int i = 0; i < 9; i++) check_eq($sformatf("rd_order_%0d", i), a_rd_log[i], exp_rd[i]);
        check_eq("lone_cell_dies", a_page_vec(1), 16'h0000);

        // 8x8 blinker, two generations
        for (int i = 0; i < 128; i++) b_mem[i] = 1'b0;
        b_mem[26] = 1'b1; b_mem[27] = 1'b1; b_mem[28] = 1'b1;
        run_gen(1'b1, 1'b0, 900);
        check_eq("blinker_vertical", b_page_vec(1), (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35));
        check_eq("blinker_page1", b_page, 1);
        run_gen(1'b1, 1'b0, 900);
        check_eq("blinker_horizontal", b_page_vec(0), (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28));
        check_eq("blinker_page0", b_page, 0);

        // fully populated 8x8 grid: overcrowding kills every cell
        for (int i = 0; i < 64; i++) b_mem[i] = 1'b1;
        for (int i = 64; i < 128; i++) b_mem[i] = 1'b1;
        b_max = 0;
        run_gen(1'b1, 1'b0, 900);
        check_eq("all_live_next", b_page_vec(1), 64'd0);
        check_eq("all_live_max_ncount", b_max, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
